// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: state encoding, width and
// the quotient value reported when dividing by zero.
package div_pkg;

    localparam int DIV_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [DIV_WIDTH-1:0] DIV_BY_ZERO_QUOTIENT = '1;

endpackage

// File: rtl/div_sub_step.sv
// Combinational ripple subtractor: difference = minuend + ~subtrahend + 1.
// borrow is the inverted carry out of the top bit (1 when minuend < subtrahend).
module div_sub_step
    import div_pkg::*;
#(
    parameter int N = DIV_WIDTH + 1
) (
    input  logic [N-1:0] minuend,
    input  logic [N-1:0] subtrahend,
    output logic [N-1:0] difference,
    output logic         borrow
);

    logic [N:0]   carry;
    logic [N-1:0] sub_inv;

    assign sub_inv  = ~subtrahend;
    assign carry[0] = 1'b1;

    // One full adder per bit, carry rippling from LSB to MSB.
    for (genvar i = 0; i < N; i++) begin : g_bit
        assign difference[i] = minuend[i] ^ sub_inv[i] ^ carry[i];
        assign carry[i+1]    = (minuend[i] & sub_inv[i]) |
                               (carry[i] & (minuend[i] ^ sub_inv[i]));
    end

    assign borrow = ~carry[N];

endmodule

// File: rtl/seq_divider16.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Handshake: start is sampled only in IDLE or DONE; an accepted start with a
// nonzero divisor occupies RUN for WIDTH cycles, then done pulses for one
// cycle with quotient/remainder valid; those results hold until the next
// accepted start. A zero divisor goes straight to DONE with the flag set.
module seq_divider16
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_n;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;
    logic             borrow;
    logic             can_start;
    logic             r_msb_unused;

    // Between iterations R < divisor, so its top bit is always zero and only
    // the low WIDTH bits feed the next shift.
    assign r_msb_unused = r[WIDTH];

    assign can_start = start && (state == IDLE || state == DONE);
    assign r_shift   = {r[WIDTH-1:0], q[WIDTH-1]};

    div_sub_step #(.N(WIDTH + 1)) u_sub (
        .minuend    (r_shift),
        .subtrahend ({1'b0, d}),
        .difference (diff),
        .borrow     (borrow)
    );

    // Restore on borrow; the quotient bit is the inverted borrow.
    assign r_next = borrow ? r_shift : diff;
    assign q_next = {q[WIDTH-2:0], ~borrow};

    assign busy = (state == RUN);

    // State register; done is registered as "next state is DONE".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            done  <= (state_n == DONE);
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = (divisor == '0) ? DONE : RUN;
                end else begin
                    state_n = IDLE;
                end
            end
            RUN: begin
                if (count == LAST) begin
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration registers and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '0;
            r           <= '0;
            q           <= '0;
            d           <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (can_start) begin
            if (divisor != '0) begin
                d           <= divisor;
                r           <= '0;
                q           <= dividend;
                count       <= '0;
                div_by_zero <= 1'b0;
            end else begin
                quotient    <= DIV_BY_ZERO_QUOTIENT;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (state == RUN) begin
            r     <= r_next;
            q     <= q_next;
            count <= count + CW'(1);
            if (count == LAST) begin
                quotient  <= q_next;
                remainder <= r_next[WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_seq_divider16.sv
// Bench for seq_divider16: reset checks, a vector table, hand-written corner
// sequences and randomized operands against an arithmetic reference model.
module tb_seq_divider16;
    import div_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    // Expected results: {div_by_zero, quotient, remainder}.
    logic [2*W:0] exp_q[$];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ez;
    } vec_t;

    vec_t vecs[7];

    seq_divider16 dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference model: plain integer division.
    function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) return {1'b1, {W{1'b1}}, a};
        return {1'b0, a / b, a % b};
    endfunction

    task automatic wait_done(input int max_edges, output int n);
        n = 0;
        while (!done && n < max_edges) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // Driver + scoreboard for one complete operation.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic ez, input string tag);
        logic [2*W:0] e;
        int lat;
        int exp_lat;
        exp_lat = (b == '0) ? 0 : W;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        exp_q.push_back({ez, eq, er});
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        lat = 0;
        while (!done && lat < 4 * W) begin
            check({tag, " busy"}, 32'(busy), 32'(b != '0));
            @(posedge clk); #1;
            lat++;
        end
        e = exp_q.pop_front();
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy at done"}, 32'(busy), 32'd0);
        check({tag, " quotient"}, 32'(quotient), 32'(e[2*W-1:W]));
        check({tag, " remainder"}, 32'(remainder), 32'(e[W-1:0]));
        check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(e[2*W]));
        @(posedge clk); #1;
        check({tag, " done width"}, 32'(done), 32'd0);
        check({tag, " quotient hold"}, 32'(quotient), 32'(e[2*W-1:W]));
        check({tag, " remainder hold"}, 32'(remainder), 32'(e[W-1:0]));
    endtask

    initial begin
        int n;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2*W:0] m;

        vecs[0] = '{a: 16'd100,   b: 16'd7,      eq: 16'd14,   er: 16'd2,    ez: 1'b0};
        vecs[1] = '{a: 16'hFFFF,  b: 16'd1,      eq: 16'hFFFF, er: 16'd0,    ez: 1'b0};
        vecs[2] = '{a: 16'h1234,  b: 16'h1235,   eq: 16'd0,    er: 16'h1234, ez: 1'b0};
        vecs[3] = '{a: 16'hBEEF,  b: 16'd0,      eq: 16'hFFFF, er: 16'hBEEF, ez: 1'b1};
        vecs[4] = '{a: 16'd0,     b: 16'd5,      eq: 16'd0,    er: 16'd0,    ez: 1'b0};
        vecs[5] = '{a: 16'hFFFF,  b: 16'hFFFF,   eq: 16'd1,    er: 16'd0,    ez: 1'b0};
        vecs[6] = '{a: 16'hFFFE,  b: 16'h8000,   eq: 16'd1,    er: 16'h7FFE, ez: 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset quotient", 32'(quotient), 32'd0);
        check("reset remainder", 32'(remainder), 32'd0);
        check("reset dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle done", 32'(done), 32'd0);
        check("idle busy", 32'(busy), 32'd0);

        // Vector table
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].eq, vecs[i].er, vecs[i].ez, "vec");
        end

        // Start while busy: second start ignored, original result on time
        @(negedge clk);
        dividend = 16'd100; divisor = 16'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        dividend = 16'd9; divisor = 16'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy-start busy", 32'(busy), 32'd1);
        wait_done(4 * W, n);
        check("busy-start latency", n + 5, W);
        check("busy-start quotient", 32'(quotient), 32'd14);
        check("busy-start remainder", 32'(remainder), 32'd2);
        @(posedge clk); #1;
        check("busy-start no restart", 32'(busy), 32'd0);

        // Asynchronous reset mid-RUN
        @(negedge clk);
        dividend = 16'd1000; divisor = 16'd10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst quotient", 32'(quotient), 32'd0);
        check("midrst remainder", 32'(remainder), 32'd0);
        check("midrst dbz", 32'(div_by_zero), 32'd0);
        check("midrst state", 32'(dut.state), 32'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < W + 2; k++) begin
            @(posedge clk); #1;
            check("midrst no done", 32'(done), 32'd0);
        end
        run_op(16'd1000, 16'd10, 16'd100, 16'd0, 1'b0, "post-rst");

        // Back-to-back: start held, new operands loaded in the DONE cycle
        @(negedge clk);
        dividend = 16'd1000; divisor = 16'd10; start = 1'b1;
        @(posedge clk); #1;
        wait_done(4 * W, n);
        check("b2b first latency", n, W);
        check("b2b first done", 32'(done), 32'd1);
        check("b2b first quotient", 32'(quotient), 32'd100);
        check("b2b first remainder", 32'(remainder), 32'd0);
        dividend = 16'd65535; divisor = 16'd255;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b done drops", 32'(done), 32'd0);
        check("b2b busy again", 32'(busy), 32'd1);
        wait_done(4 * W, n);
        check("b2b spacing", n + 1, W + 1);
        check("b2b second quotient", 32'(quotient), 32'd257);
        check("b2b second remainder", 32'(remainder), 32'd0);
        check("b2b second dbz", 32'(div_by_zero), 32'd0);
        @(posedge clk); #1;

        // Randomized operands against the arithmetic model
        for (int k = 0; k < 40; k++) begin
            a = W'($urandom);
            case ($urandom_range(0, 9))
                0:          b = '0;
                1, 2, 3, 4: b = W'($urandom_range(1, 255));
                default:    b = W'($urandom);
            endcase
            m = model(a, b);
            run_op(a, b, m[2*W-1:W], m[W-1:0], m[2*W], "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_divider16.md
# seq_divider16

Sequential unsigned 16-bit restoring divider that resolves one quotient bit per clock. It is the inverse-direction companion to the array multiplier datapath. It accepts a dividend/divisor pair on a start pulse and, after a fixed latency, presents the quotient and remainder with a one-cycle done strobe. Each iteration performs its trial subtraction with a ripple subtract stage built the same way as the team's ripple adder.

## Interface
- WIDTH, 16, operand/result width in bits; all widths below scale with it.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only in IDLE or DONE.
- dividend  input  WIDTH  unsigned numerator, captured on the accepted start.
- divisor  input  WIDTH  unsigned denominator, captured on the accepted start.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle strobe; results are valid in this cycle.
- quotient  output  WIDTH  result; held until the next accepted start.
- remainder  output  WIDTH  result; held until the next accepted start.
- div_by_zero  output  1  flag for the divisor==0 case; valid with done and held with the results.

## Operation
- States:
  - IDLE: wait for start.
  - RUN: iterate.
  - DONE: present results for one cycle.
- Reset (async, any state, including mid-RUN):
  - state goes to IDLE.
  - busy, done, div_by_zero, quotient and remainder all go to 0.
  - The iteration counter and internal registers are cleared.
  - No partial result is ever presented.
- IDLE or DONE with start=1 and divisor!=0:
  - Capture the operands.
  - Set the partial remainder R (WIDTH+1 bits) to 0 and the shift register Q to dividend.
  - Set count to 0, clear div_by_zero, and go to RUN.
- IDLE or DONE with start=1 and divisor==0:
  - Go to DONE on the next edge.
  - quotient = all ones (0xFFFF), remainder = dividend, div_by_zero = 1.
- RUN iteration (one per edge):
  - Form R' = {R[WIDTH-1:0], Q[WIDTH-1]} and compute T = R' − {0, divisor}, WIDTH+1 bits with borrow.
  - If there is no borrow: R = T and shift a 1 into the Q LSB.
  - If there is a borrow: R = R' and shift a 0 into the Q LSB.
  - count increments. After iteration WIDTH (count reaches WIDTH−1 then wraps), go to DONE.
- Transition into DONE: quotient = Q and remainder = R[WIDTH-1:0] are loaded, and done = 1.
- DONE with no start: go to IDLE on the next edge. done drops; results and div_by_zero hold.
- start in RUN is ignored (no queueing, no restart). Operand inputs may change freely while not being captured.
- Arithmetic is unsigned only. Remainder is always < divisor when divisor != 0. quotient·divisor + remainder = dividend is exact.

## Timing
- Accepted start at edge 0 → busy high from after edge 0 through edge WIDTH.
- done high in the cycle after edge WIDTH: latency of 16 clocks for WIDTH=16.
- Divide-by-zero: done high in the cycle after edge 0, for a latency of 1. busy never asserts.
- done is exactly one cycle wide unless start is accepted in that DONE cycle. In that case the next operation begins and done drops.
- Back-to-back throughput: one result every WIDTH+1 cycles.
- Outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package div_pkg holds:
  - the state enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - DIV_WIDTH = 16.
  - the DIV_BY_ZERO_QUOTIENT constant (all ones).
- Sub-module div_sub_step: a combinational WIDTH+1-bit ripple subtractor.
  - Inputs: minuend, subtrahend.
  - Outputs: difference, borrow.
  - It computes A + ~B + 1 with per-bit carry chain logic in the same ripple style as the team adder.
- Top level holds the FSM, the count, R/Q registers and the output registers. It instantiates div_sub_step once.

## Test plan
- Basic division: dividend=100, divisor=7, start at edge 0 → done in the cycle after edge 16, quotient=14, remainder=2, div_by_zero=0. busy is high during cycles 1–16.
- Extreme operands:
  - 0xFFFF/1 → quotient=0xFFFF, remainder=0.
  - 0x1234/0x1235 (divisor > dividend) → quotient=0, remainder=0x1234.
- Divide by zero: dividend=0xBEEF, divisor=0 → done one cycle after start, quotient=0xFFFF, remainder=0xBEEF, div_by_zero=1, busy stays 0.
- Start while busy: start pulsed again at cycle 5 of a RUN with different operands → ignored; the original result is delivered at the original time.
- Reset mid-operation: rst asserted asynchronously mid-RUN at cycle 8 → all outputs 0 immediately, state IDLE, no done. A new start after release gives a correct result.
- Back-to-back starts: start held high with 1000/10, then 65535/255 loaded in the DONE cycle → done strobes 17 cycles apart, with results 100/0 then 257/0.
